// File: rtl/fft_reorder_pkg.sv
// Shared constants, types and index helpers for the FFT output reorder buffer.
package fft_reorder_pkg;

  localparam int LANES         = 4;
  localparam int NBITS_OUT_DEF = 15;

  typedef logic [2*NBITS_OUT_DEF-1:0] lane_word_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  // Ceiling log2; exact for the power-of-two FFT lengths used here.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) r[5'(i)] = value[5'(width - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// Lane bus between the FFT core, the reorder buffer and the downstream consumer.
interface fft_out_reorder_if
  import fft_reorder_pkg::*;
#(
  parameter int NBITS_out = 15
);
  // No backpressure: i_enable qualifies the four input lanes in the cycle it is
  // high, o_valid qualifies the four output lanes; neither side can stall.
  logic [2*NBITS_out-1:0] fftIn0_up;
  logic [2*NBITS_out-1:0] fftIn0_down;
  logic [2*NBITS_out-1:0] fftIn1_up;
  logic [2*NBITS_out-1:0] fftIn1_down;
  logic                   i_enable;
  logic [2*NBITS_out-1:0] fftOut0;
  logic [2*NBITS_out-1:0] fftOut1;
  logic [2*NBITS_out-1:0] fftOut2;
  logic [2*NBITS_out-1:0] fftOut3;
  logic                   o_valid;
  logic                   o_frame_start;
  rd_state_e              dbg_state;

  modport slave (
    input  fftIn0_up, fftIn0_down, fftIn1_up, fftIn1_down, i_enable,
    output fftOut0, fftOut1, fftOut2, fftOut3, o_valid, o_frame_start, dbg_state
  );

  modport master (
    output fftIn0_up, fftIn0_down, fftIn1_up, fftIn1_down, i_enable,
    input  fftOut0, fftOut1, fftOut2, fftOut3, o_valid, o_frame_start, dbg_state
  );

endinterface

// File: rtl/fft_reorder_page.sv
// One N-word register page: four bit-reversed write ports, four natural-order read ports.
module fft_reorder_page
  import fft_reorder_pkg::*;
#(
  parameter int NBITS_out = 15,
  parameter int N         = 128
) (
  input  logic                         clk,
  input  logic                         we_i,
  input  logic [log2(N)-3:0]           wc_i,
  input  logic [2*NBITS_out-1:0]       wdata_i [LANES],
  input  logic [log2(N)-3:0]           rc_i,
  output logic [2*NBITS_out-1:0]       rdata_o [LANES]
);

  localparam int LOG2N = log2(N);
  localparam int W     = 2 * NBITS_out;

  logic [W-1:0]     mem_q [N];
  logic [LOG2N-1:0] waddr [LANES];

  // Lane l of write cycle wc carries scrambled index k = 4*wc + l.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      waddr[l] = LOG2N'(bitrev(32'({wc_i, 2'(l)}), LOG2N));
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int l = 0; l < LANES; l++) begin
        mem_q[waddr[l]] <= wdata_i[l];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      rdata_o[j] = mem_q[{rc_i, 2'(j)}];
    end
  end

endmodule

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT lanes in, natural-order bins out, never stalls.
module fft_out_reorder
  import fft_reorder_pkg::*;
#(
  parameter int NBITS_out = 15,
  parameter int N         = 128
) (
  input logic              clk,
  input logic              rst,
  fft_out_reorder_if.slave bus
);

  localparam int LOG2N = log2(N);
  localparam int WCW   = LOG2N - 2;
  localparam int W     = 2 * NBITS_out;
  localparam logic [WCW-1:0] CNT_LAST = '1;

  logic [WCW-1:0] wc_q;
  logic [WCW-1:0] rc_q;
  logic           wpage_q;
  logic           rpage_q;
  rd_state_e      state_q;
  logic [W-1:0]   out_q [LANES];
  logic           valid_q;
  logic           fs_q;

  logic [W-1:0]   wdata  [LANES];
  logic [W-1:0]   rdata0 [LANES];
  logic [W-1:0]   rdata1 [LANES];
  logic [W-1:0]   rdata  [LANES];
  logic           handoff;

  assign wdata[0] = bus.fftIn0_up;
  assign wdata[1] = bus.fftIn0_down;
  assign wdata[2] = bus.fftIn1_up;
  assign wdata[3] = bus.fftIn1_down;

  assign handoff = bus.i_enable && (wc_q == CNT_LAST);

  fft_reorder_page #(.NBITS_out(NBITS_out), .N(N)) u_page0 (
    .clk     (clk),
    .we_i    (bus.i_enable && !wpage_q),
    .wc_i    (wc_q),
    .wdata_i (wdata),
    .rc_i    (rc_q),
    .rdata_o (rdata0)
  );

  fft_reorder_page #(.NBITS_out(NBITS_out), .N(N)) u_page1 (
    .clk     (clk),
    .we_i    (bus.i_enable && wpage_q),
    .wc_i    (wc_q),
    .wdata_i (wdata),
    .rc_i    (rc_q),
    .rdata_o (rdata1)
  );

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      rdata[j] = rpage_q ? rdata1[j] : rdata0[j];
    end
  end

  // The reader always owns the page the writer just left, so the two never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wc_q    <= '0;
      rc_q    <= '0;
      wpage_q <= 1'b0;
      rpage_q <= 1'b0;
      state_q <= RD_IDLE;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      for (int j = 0; j < LANES; j++) out_q[j] <= '0;
    end else begin
      if (bus.i_enable) begin
        wc_q <= wc_q + 1'b1;
        if (wc_q == CNT_LAST) wpage_q <= ~wpage_q;
      end
      case (state_q)
        RD_IDLE: begin
          valid_q <= 1'b0;
          fs_q    <= 1'b0;
          if (handoff) begin
            state_q <= RD_READ;
            rc_q    <= '0;
            rpage_q <= wpage_q;
          end
        end
        RD_READ: begin
          valid_q <= 1'b1;
          fs_q    <= (rc_q == '0);
          for (int j = 0; j < LANES; j++) out_q[j] <= rdata[j];
          if (rc_q == CNT_LAST) begin
            rc_q <= '0;
            if (handoff) rpage_q <= wpage_q;
            else         state_q <= RD_IDLE;
          end else begin
            rc_q <= rc_q + 1'b1;
          end
        end
        default: state_q <= RD_IDLE;
      endcase
    end
  end

  assign bus.fftOut0       = out_q[0];
  assign bus.fftOut1       = out_q[1];
  assign bus.fftOut2       = out_q[2];
  assign bus.fftOut3       = out_q[3];
  assign bus.o_valid       = valid_q;
  assign bus.o_frame_start = fs_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Scoreboard bench for fft_out_reorder: frames of tagged/random lanes in, natural-order bins checked out.
module tb_fft_out_reorder;
  import fft_reorder_pkg::*;

  localparam int NB  = 15;
  localparam int N   = 128;
  localparam int CPF = N / 4;
  localparam int EW  = 4 * 2 * NB + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_out_reorder_if #(.NBITS_out(NB)) bus ();

  fft_out_reorder #(.NBITS_out(NB), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] exp_q [$];
  lane_word_t    fdata [N];

  function automatic int rev7(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 7; i++) begin
      if ((v & (1 << i)) != 0) r = r | (1 << (6 - i));
    end
    return r;
  endfunction

  // Fill one frame, queue its natural-order expectation, then drive it with optional idle gaps.
  task automatic drive_frame(input int mode, input int gaps);
    int gap_cnt [CPF];
    logic [EW-1:0] e;
    for (int c = 0; c < CPF; c++) gap_cnt[c] = 0;
    for (int g = 0; g < gaps; g++) gap_cnt[$urandom_range(1, CPF - 1)]++;
    for (int k = 0; k < N; k++) begin
      case (mode)
        0:       fdata[k] = 30'(k);
        1:       fdata[k] = 30'($urandom);
        default: case (k % 4)
                   0:       fdata[k] = {15'h3FFF, 15'h4000};
                   1:       fdata[k] = {15'h4000, 15'h3FFF};
                   2:       fdata[k] = {15'h7FFF, 15'h7FFF};
                   default: fdata[k] = {15'h0000, 15'h0001};
                 endcase
      endcase
    end
    for (int c = 0; c < CPF; c++) begin
      e = {(c == 0), fdata[rev7(4*c+3)], fdata[rev7(4*c+2)], fdata[rev7(4*c+1)], fdata[rev7(4*c)]};
      exp_q.push_back(e);
    end
    for (int c = 0; c < CPF; c++) begin
      repeat (gap_cnt[c]) begin
        @(negedge clk);
        bus.i_enable    = 1'b0;
        bus.fftIn0_up   = 30'($urandom);
        bus.fftIn0_down = 30'($urandom);
        bus.fftIn1_up   = 30'($urandom);
        bus.fftIn1_down = 30'($urandom);
      end
      @(negedge clk);
      bus.i_enable    = 1'b1;
      bus.fftIn0_up   = fdata[4*c];
      bus.fftIn0_down = fdata[4*c+1];
      bus.fftIn1_up   = fdata[4*c+2];
      bus.fftIn1_down = fdata[4*c+3];
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.o_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b want=0", bus.o_valid);
    end
    checks++;
    if (bus.o_frame_start !== 1'b0) begin
      failures++; $display("FAIL reset_frame_start got=%b want=0", bus.o_frame_start);
    end
    checks++;
    if ({bus.fftOut3, bus.fftOut2, bus.fftOut1, bus.fftOut0} !== 120'd0) begin
      failures++; $display("FAIL reset_lanes got=%h want=0", {bus.fftOut3, bus.fftOut2, bus.fftOut1, bus.fftOut0});
    end
    checks++;
    if (bus.dbg_state !== RD_IDLE) begin
      failures++; $display("FAIL reset_state got=%0d want=%0d", bus.dbg_state, RD_IDLE);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_stream(input string name, input int nframes, input int mode, input int gaps);
    int n, first_n, vcnt, drop;
    logic [EW-1:0] e, got, last_e;
    n = 0; first_n = -1; vcnt = 0; drop = 0; last_e = '0;
    fork
      begin
        for (int f = 0; f < nframes; f++) drive_frame(mode, gaps);
        @(negedge clk);
        bus.i_enable = 1'b0;
      end
      begin
        repeat (CPF * nframes + 8 * gaps + 60) begin
          @(negedge clk);
          n++;
          got = {bus.o_frame_start, bus.fftOut3, bus.fftOut2, bus.fftOut1, bus.fftOut0};
          if (bus.o_valid === 1'b1) begin
            if (first_n < 0) first_n = n;
            vcnt++;
            checks++;
            if (exp_q.size() == 0) begin
              failures++; $display("FAIL %s_extra_output got=%h want=none", name, got);
            end else begin
              e = exp_q.pop_front();
              last_e = e;
              if (got !== e) begin
                failures++; $display("FAIL %s_bins cyc=%0d got=%h want=%h", name, vcnt - 1, got, e);
              end
            end
          end else if (first_n >= 0 && vcnt < CPF * nframes && gaps == 0) begin
            drop++;
          end
        end
      end
    join
    checks++;
    if (vcnt != CPF * nframes) begin
      failures++; $display("FAIL %s_valid_count got=%0d want=%0d", name, vcnt, CPF * nframes);
    end
    checks++;
    if (first_n != CPF + 2 + gaps) begin
      failures++; $display("FAIL %s_latency got=%0d want=%0d", name, first_n, CPF + 2 + gaps);
    end
    checks++;
    if (drop != 0) begin
      failures++; $display("FAIL %s_valid_drop got=%0d want=0", name, drop);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL %s_missing_outputs got=%0d want=0", name, exp_q.size());
    end
    checks++;
    if (bus.o_valid !== 1'b0 ||
        {bus.fftOut3, bus.fftOut2, bus.fftOut1, bus.fftOut0} !== last_e[EW-2:0]) begin
      failures++;
      $display("FAIL %s_hold got=%b/%h want=0/%h", name, bus.o_valid,
               {bus.fftOut3, bus.fftOut2, bus.fftOut1, bus.fftOut0}, last_e[EW-2:0]);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int vcnt, k;
    logic [EW-1:0] e, got;
    vcnt = 0; k = 0;
    exp_q.delete();
    fork
      begin
        drive_frame(1, 0);
        for (int c = 0; c <= 17; c++) begin
          @(negedge clk);
          bus.i_enable    = 1'b1;
          bus.fftIn0_up   = 30'($urandom);
          bus.fftIn0_down = 30'($urandom);
          bus.fftIn1_up   = 30'($urandom);
          bus.fftIn1_down = 30'($urandom);
        end
        #2 rst = 1'b0;
      end
      begin
        while (k < 80 && rst) begin
          @(negedge clk);
          k++;
          if (rst && bus.o_valid === 1'b1) begin
            vcnt++;
            got = {bus.o_frame_start, bus.fftOut3, bus.fftOut2, bus.fftOut1, bus.fftOut0};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
              failures++; $display("FAIL midreset_bins cyc=%0d got=%h want=%h", vcnt - 1, got, e);
            end
          end
        end
      end
    join
    #1;
    checks++;
    if (vcnt != 17) begin
      failures++; $display("FAIL midreset_read_progress got=%0d want=17", vcnt);
    end
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_frame_start !== 1'b0) begin
      failures++; $display("FAIL midreset_flags got=%b%b want=00", bus.o_valid, bus.o_frame_start);
    end
    checks++;
    if ({bus.fftOut3, bus.fftOut2, bus.fftOut1, bus.fftOut0} !== 120'd0) begin
      failures++; $display("FAIL midreset_lanes got=%h want=0", {bus.fftOut3, bus.fftOut2, bus.fftOut1, bus.fftOut0});
    end
    checks++;
    if (bus.dbg_state !== RD_IDLE) begin
      failures++; $display("FAIL midreset_state got=%0d want=%0d", bus.dbg_state, RD_IDLE);
    end
    bus.i_enable = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    test_stream("post_reset", 1, 0, 0);
  endtask

  initial begin
    bus.i_enable    = 1'b0;
    bus.fftIn0_up   = '0;
    bus.fftIn0_down = '0;
    bus.fftIn1_up   = '0;
    bus.fftIn1_down = '0;
    test_reset();
    test_stream("single", 1, 0, 0);
    test_stream("back_to_back", 4, 1, 0);
    test_stream("gaps", 1, 0, 5);
    test_stream("extreme", 1, 2, 0);
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
